// File: rtl/switch_scan_controller.sv
// ----------------------------------------------------------------------------
// switch_scan_controller
//
// Sweeps a one-hot switch select across a range of channels of the photonic
// switch bank. Each channel is held for a programmable settle interval and
// then a dwell interval during which the measurement window is open. The
// channel order is ascending or descending and wraps around the bank edge.
// Experiment control sees a start / busy / done handshake.
//
// Parameters
//   NCH  number of switch channels (2..16)
//   CW   channel index width
//   TW   settle/dwell timer width
//
// Ports
//   clk_i         system clock, rising edge
//   reset_i       synchronous, active-low reset
//   start_i       sweep request, only looked at while idle
//   abort_i       terminates a sweep, wins over everything except reset
//   dir_i         0 = ascending channel order, 1 = descending
//   first_ch_i    first channel of the sweep
//   last_ch_i     last channel of the sweep
//   settle_i      settle length minus one, in cycles
//   dwell_i       dwell length minus one, in cycles
//   sw_sel_o      registered one-hot switch drive
//   ch_o          registered current channel index
//   busy_o        high while settling or dwelling
//   meas_en_o     measurement window, high while dwelling
//   ch_done_o     one-cycle pulse after each channel's last dwell cycle
//   done_o        one-cycle pulse when the sweep completes
//   err_o         one-cycle pulse when a start is rejected for a bad range
// ----------------------------------------------------------------------------
module switch_scan_controller #(
    parameter int NCH = 8,
    parameter int CW  = $clog2(NCH),
    parameter int TW  = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic           dir_i,
    input  logic [CW-1:0]  first_ch_i,
    input  logic [CW-1:0]  last_ch_i,
    input  logic [TW-1:0]  settle_i,
    input  logic [TW-1:0]  dwell_i,
    output logic [NCH-1:0] sw_sel_o,
    output logic [CW-1:0]  ch_o,
    output logic           busy_o,
    output logic           meas_en_o,
    output logic           ch_done_o,
    output logic           done_o,
    output logic           err_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic           dirLat_q, dirLat_d;
    logic [CW-1:0]  lastLat_q, lastLat_d;
    logic [TW-1:0]  settleLat_q, settleLat_d;
    logic [TW-1:0]  dwellLat_q, dwellLat_d;
    logic [NCH-1:0] swSel_q, swSel_d;
    logic           busy_q, busy_d;
    logic           measEn_q, measEn_d;
    logic           chDone_q, chDone_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [CW-1:0]  chNext;
    logic           rangeOk;

    // Successor channel in the latched direction, wrapping at both bank edges.
    always_comb begin
        if (!dirLat_q) begin
            chNext = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
        end else begin
            chNext = (ch_q == '0) ? CW'(NCH - 1) : ch_q - CW'(1);
        end
    end

    // The index width can address more channels than the bank has.
    assign rangeOk = (int'(first_ch_i) < NCH) && (int'(last_ch_i) < NCH);

    // Next-state logic. Pulses default low so they last exactly one cycle;
    // sweep parameters are only captured on an accepted start so that inputs
    // moving mid-sweep cannot disturb it.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ch_d        = ch_q;
        dirLat_d    = dirLat_q;
        lastLat_d   = lastLat_q;
        settleLat_d = settleLat_q;
        dwellLat_d  = dwellLat_q;
        chDone_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (rangeOk) begin
                            dirLat_d    = dir_i;
                            lastLat_d   = last_ch_i;
                            settleLat_d = settle_i;
                            dwellLat_d  = dwell_i;
                            ch_d        = first_ch_i;
                            timer_d     = '0;
                            state_d     = SETTLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (timer_q == settleLat_q) begin
                        timer_d = '0;
                        state_d = DWELL;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                DWELL: begin
                    if (timer_q == dwellLat_q) begin
                        timer_d  = '0;
                        chDone_d = 1'b1;
                        if (ch_q == lastLat_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            ch_d    = chNext;
                            state_d = SETTLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so that, once registered,
    // they line up with the state itself. Switching from one channel to the
    // next therefore moves the one-hot directly with no all-zero cycle.
    always_comb begin
        busy_d   = (state_d == SETTLE) || (state_d == DWELL);
        measEn_d = (state_d == DWELL);
        swSel_d  = busy_d ? ({{(NCH - 1){1'b0}}, 1'b1} << ch_d) : '0;
    end

    // State, latched sweep parameters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            ch_q        <= '0;
            dirLat_q    <= 1'b0;
            lastLat_q   <= '0;
            settleLat_q <= '0;
            dwellLat_q  <= '0;
            swSel_q     <= '0;
            busy_q      <= 1'b0;
            measEn_q    <= 1'b0;
            chDone_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ch_q        <= ch_d;
            dirLat_q    <= dirLat_d;
            lastLat_q   <= lastLat_d;
            settleLat_q <= settleLat_d;
            dwellLat_q  <= dwellLat_d;
            swSel_q     <= swSel_d;
            busy_q      <= busy_d;
            measEn_q    <= measEn_d;
            chDone_q    <= chDone_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sw_sel_o  = swSel_q;
    assign ch_o      = ch_q;
    assign busy_o    = busy_q;
    assign meas_en_o = measEn_q;
    assign ch_done_o = chDone_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_switch_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_switch_scan_controller
//
// Drives an 8-channel and a 6-channel controller from the same inputs. A
// schedule-based model predicts every output of both from the sweep start
// time and the channel arithmetic; the outputs are compared every cycle.
// Directed sweeps add literal expectations on channel order, pulse counts
// and done timing.
// ----------------------------------------------------------------------------
module tb_switch_scan_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       dir;
    logic [2:0] firstCh;
    logic [2:0] lastCh;
    logic [3:0] settle;
    logic [3:0] dwell;

    logic [7:0] sw8;
    logic [2:0] ch8;
    logic       busy8, meas8, chDone8, done8, err8;
    logic [5:0] sw6;
    logic [2:0] ch6;
    logic       busy6, meas6, chDone6, done6, err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_scan_controller #(.NCH(8), .CW(3), .TW(4)) u8 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .dir_i(dir), .first_ch_i(firstCh), .last_ch_i(lastCh),
        .settle_i(settle), .dwell_i(dwell),
        .sw_sel_o(sw8), .ch_o(ch8), .busy_o(busy8), .meas_en_o(meas8),
        .ch_done_o(chDone8), .done_o(done8), .err_o(err8)
    );

    switch_scan_controller #(.NCH(6), .CW(3), .TW(4)) u6 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .dir_i(dir), .first_ch_i(firstCh), .last_ch_i(lastCh),
        .settle_i(settle), .dwell_i(dwell),
        .sw_sel_o(sw6), .ch_o(ch6), .busy_o(busy6), .meas_en_o(meas6),
        .ch_done_o(chDone6), .done_o(done6), .err_o(err6)
    );

    // Model state, index 0 = 8-channel instance, index 1 = 6-channel instance.
    int tick = 0;
    bit modelValid = 0;
    int nchOf [2] = '{8, 6};
    bit active [2];
    int t0 [2];
    int mDir [2], mFirst [2], mLast [2], mS [2], mD [2], mK [2];
    logic [15:0] expSw [2];
    int expCh [2];
    bit expBusy [2], expMeas [2], expChDone [2], expDone [2], expErr [2];

    function automatic int chAt(input int first, input int idx, input int d, input int n);
        if (d == 0) return (first + idx) % n;
        return ((first - idx) % n + n) % n;
    endfunction

    // Predicts the outputs following the current edge for one instance. An
    // accepted sweep is described purely by its start edge: offset t falls in
    // channel t/period at phase t%period, the done cycle is at K*period and the
    // controller is idle again one edge later.
    task automatic modelStep(input int i);
        int t, per, idx, ph, n;
        n = nchOf[i];
        expErr[i] = 0; expDone[i] = 0; expChDone[i] = 0;
        expBusy[i] = 0; expMeas[i] = 0; expSw[i] = '0;
        if (!reset) begin
            active[i] = 0;
            expCh[i] = 0;
            return;
        end
        if (active[i]) begin
            t = tick - t0[i];
            per = mS[i] + mD[i] + 2;
            if (abort || t > mK[i] * per) begin
                active[i] = 0;
            end else begin
                idx = t / per;
                ph = t % per;
                if (idx < mK[i]) begin
                    expCh[i] = chAt(mFirst[i], idx, mDir[i], n);
                    expBusy[i] = 1;
                    expMeas[i] = (ph > mS[i]);
                    expSw[i] = 16'(1) << expCh[i];
                end else begin
                    expDone[i] = 1;
                end
                if (ph == 0 && idx > 0) expChDone[i] = 1;
            end
            return;
        end
        if (abort) return;
        if (start) begin
            if (int'(firstCh) < n && int'(lastCh) < n) begin
                active[i] = 1;
                t0[i] = tick;
                mDir[i] = int'(dir);
                mFirst[i] = int'(firstCh);
                mLast[i] = int'(lastCh);
                mS[i] = int'(settle);
                mD[i] = int'(dwell);
                if (mDir[i] == 0) mK[i] = ((mLast[i] - mFirst[i]) % n + n) % n + 1;
                else mK[i] = ((mFirst[i] - mLast[i]) % n + n) % n + 1;
                expCh[i] = mFirst[i];
                expBusy[i] = 1;
                expSw[i] = 16'(1) << mFirst[i];
            end else begin
                expErr[i] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        tick++;
        modelStep(0);
        modelStep(1);
        modelValid = 1;
    end

    task automatic cmpOut(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d tick %0d: got %0h expected %0h", name, inst, tick, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Observation records for the directed expectations.
    int seq0 [$];
    int startTick0, doneTick0, chDoneCnt0, measCnt0, doneCnt0;
    int errCnt1, busyCnt1;
    bit prevBusy8 = 0;
    logic [2:0] prevCh8 = '0;

    task automatic resetRecord();
        seq0.delete();
        startTick0 = -1; doneTick0 = -1;
        chDoneCnt0 = 0; measCnt0 = 0; doneCnt0 = 0;
        errCnt1 = 0; busyCnt1 = 0;
    endtask

    // Every-cycle comparison against the model, then bookkeeping.
    always @(negedge clk) begin
        if (modelValid) begin
            cmpOut("sw_sel", 0, int'(sw8), int'(expSw[0]));
            cmpOut("ch", 0, int'(ch8), expCh[0]);
            cmpOut("busy", 0, int'(busy8), int'(expBusy[0]));
            cmpOut("meas_en", 0, int'(meas8), int'(expMeas[0]));
            cmpOut("ch_done", 0, int'(chDone8), int'(expChDone[0]));
            cmpOut("done", 0, int'(done8), int'(expDone[0]));
            cmpOut("err", 0, int'(err8), int'(expErr[0]));
            cmpOut("sw_sel", 1, int'(sw6), int'(expSw[1]));
            cmpOut("ch", 1, int'(ch6), expCh[1]);
            cmpOut("busy", 1, int'(busy6), int'(expBusy[1]));
            cmpOut("meas_en", 1, int'(meas6), int'(expMeas[1]));
            cmpOut("ch_done", 1, int'(chDone6), int'(expChDone[1]));
            cmpOut("done", 1, int'(done6), int'(expDone[1]));
            cmpOut("err", 1, int'(err6), int'(expErr[1]));

            if (busy8 && (!prevBusy8 || ch8 != prevCh8)) seq0.push_back(int'(ch8));
            if (busy8 && !prevBusy8 && startTick0 < 0) startTick0 = tick;
            if (chDone8) chDoneCnt0++;
            if (meas8) measCnt0++;
            if (done8) begin
                doneCnt0++;
                doneTick0 = tick;
            end
            if (err6) errCnt1++;
            if (busy6) busyCnt1++;
            prevBusy8 = busy8;
            prevCh8 = ch8;
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Presents a start for one edge; called just after a falling edge.
    task automatic applyStimulus(input int f, input int l, input int d, input int s, input int w);
        firstCh = 3'(f);
        lastCh = 3'(l);
        dir = d[0];
        settle = 4'(s);
        dwell = 4'(w);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic checkSeq(input string name, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        checkOutput({name, "_len"}, seq0.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < seq0.size()) checkOutput({name, "_ch"}, seq0[k], e[k]);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; abort = 1'b0; dir = 1'b0;
        firstCh = 3'd2; lastCh = 3'd2; settle = 4'd0; dwell = 4'd0;
        resetRecord();

        // Reset held with start asserted.
        repeat (3) nextCycle();
        checkOutput("rst_busy", int'(busy8), 0);
        checkOutput("rst_sw_sel", int'(sw8), 0);
        checkOutput("rst_ch", int'(ch8), 0);
        checkOutput("rst_done", int'(done8), 0);
        resetRecord();
        reset = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput("release_sw_sel", int'(sw8), 4);
        checkOutput("release_busy", int'(busy8), 1);
        repeat (4) nextCycle();
        checkOutput("release_done_at", doneTick0 - startTick0, 2);

        // Ascending with wrap; the 6-channel bank rejects first=6.
        resetRecord();
        applyStimulus(6, 1, 0, 1, 2);
        repeat (24) nextCycle();
        checkSeq("asc", 6, 7, 0, 1);
        checkOutput("asc_ch_done_cnt", chDoneCnt0, 4);
        checkOutput("asc_meas_cycles", measCnt0, 12);
        checkOutput("asc_done_at", doneTick0 - startTick0, 20);
        checkOutput("asc_done_cnt", doneCnt0, 1);
        checkOutput("asc_err6_cnt", errCnt1, 1);

        // Descending with wrap; the 6-channel bank rejects last=6.
        resetRecord();
        applyStimulus(1, 6, 1, 0, 0);
        repeat (12) nextCycle();
        checkSeq("desc", 1, 0, 7, 6);
        checkOutput("desc_meas_cycles", measCnt0, 4);
        checkOutput("desc_ch_done_cnt", chDoneCnt0, 4);
        checkOutput("desc_done_at", doneTick0 - startTick0, 8);
        checkOutput("desc_err6_cnt", errCnt1, 1);

        // Abort during the dwell of channel 3, then an immediate restart.
        resetRecord();
        applyStimulus(3, 5, 0, 1, 2);
        nextCycle();
        nextCycle();
        checkOutput("abort_pre_meas", int'(meas8), 1);
        checkOutput("abort_pre_ch", int'(ch8), 3);
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
        checkOutput("abort_busy", int'(busy8), 0);
        checkOutput("abort_sw_sel", int'(sw8), 0);
        checkOutput("abort_meas", int'(meas8), 0);
        checkOutput("abort_ch_done_cnt", chDoneCnt0, 0);
        checkOutput("abort_done_cnt", doneCnt0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("restart_busy", int'(busy8), 1);
        checkOutput("restart_sw_sel", int'(sw8), 1);
        repeat (4) nextCycle();
        checkOutput("restart_done_cnt", doneCnt0, 1);
        checkOutput("restart_ch_done_cnt", chDoneCnt0, 1);

        // Start pulsed mid-sweep with different settings.
        resetRecord();
        applyStimulus(6, 1, 0, 1, 2);
        repeat (5) nextCycle();
        firstCh = 3'd3; lastCh = 3'd1; dir = 1'b1; settle = 4'd5; dwell = 4'd7;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        repeat (60) nextCycle();
        checkSeq("busy_start", 6, 7, 0, 1);
        checkOutput("busy_start_done_at", doneTick0 - startTick0, 20);
        checkOutput("busy_start_meas_cycles", measCnt0, 12);
        checkOutput("busy_start_ch_done_cnt", chDoneCnt0, 4);

        // Abort in idle overrides start: no sweep and no error.
        resetRecord();
        firstCh = 3'd7; lastCh = 3'd0;
        abort = 1'b1;
        start = 1'b1;
        nextCycle();
        abort = 1'b0;
        start = 1'b0;
        nextCycle();
        checkOutput("idle_abort_busy", int'(busy8), 0);
        checkOutput("idle_abort_err6_cnt", errCnt1, 0);

        // first=7 is out of range only for the 6-channel bank.
        resetRecord();
        applyStimulus(7, 0, 0, 0, 0);
        repeat (8) nextCycle();
        checkOutput("illegal_err6_cnt", errCnt1, 1);
        checkOutput("illegal_busy6_cycles", busyCnt1, 0);
        checkOutput("illegal_u8_done_at", doneTick0 - startTick0, 4);

        // Maximum settle and dwell on a single channel.
        resetRecord();
        applyStimulus(4, 4, 0, 15, 15);
        repeat (36) nextCycle();
        checkOutput("max_done_at", doneTick0 - startTick0, 32);
        checkOutput("max_meas_cycles", measCnt0, 16);
        checkOutput("max_ch_done_cnt", chDoneCnt0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
